// File: rtl/seq_timing_ctrl_if.sv
// seq_timing_ctrl_if: sequence-counter feedback, IR fields and control strobes of the instruction-cycle controller
interface seq_timing_ctrl_if #(
  parameter int SC_W  = 3,
  parameter int CNT_W = 16
);
  logic [SC_W-1:0]    sc_number;
  logic               run;
  logic               halt_req;
  logic [2:0]         ir_op;
  logic               ir_ind;
  logic               exec_done;
  logic [2**SC_W-1:0] t_sig;
  logic               sc_inc;
  logic               sc_clr;
  logic               ld_ar;
  logic               ld_ir;
  logic               dec_stb;
  logic               ind_stb;
  logic               instr_done;
  logic               halted;
  logic               err_timeout;
  logic [CNT_W-1:0]   instr_count;
  modport slave (
    input  sc_number, run, halt_req, ir_op, ir_ind, exec_done,
    output t_sig, sc_inc, sc_clr, ld_ar, ld_ir, dec_stb, ind_stb,
           instr_done, halted, err_timeout, instr_count
  );
  modport master (
    output sc_number, run, halt_req, ir_op, ir_ind, exec_done,
    input  t_sig, sc_inc, sc_clr, ld_ar, ld_ir, dec_stb, ind_stb,
           instr_done, halted, err_timeout, instr_count
  );
endinterface

// File: rtl/seq_timing_ctrl.sv
// seq_timing_ctrl: fetch/decode/indirect/execute sequencer closing the loop around an external sequence counter
module seq_timing_ctrl #(
  parameter int SC_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  seq_timing_ctrl_if.slave   bus
);
  localparam int NUM_T = 2**SC_W;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_INDIRECT, S_EXECUTE, S_HALTED} state_t;
  state_t           r_state, w_next;
  logic             r_halt_pend, r_err_timeout;
  logic [CNT_W-1:0] r_instr_count;
  logic [NUM_T-1:0] w_dec;
  logic             w_active, w_zero, w_retire, w_timeout, w_resume;
  assign w_dec     = NUM_T'(1) << bus.sc_number;
  assign w_zero    = bus.sc_number == '0;
  assign w_active  = r_state inside {S_FETCH, S_DECODE, S_INDIRECT, S_EXECUTE};
  assign w_retire  = r_state == S_EXECUTE && bus.exec_done;
  // exec_done on the last timing slot still retires normally
  assign w_timeout = r_state == S_EXECUTE && !bus.exec_done && bus.sc_number == SC_W'(NUM_T-1);
  assign w_resume  = r_state == S_HALTED && bus.run && !bus.halt_req && w_zero;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = (bus.run && w_zero) ? S_FETCH : S_IDLE;
      S_FETCH:    w_next = (bus.sc_number == SC_W'(1)) ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = (bus.ir_ind && bus.ir_op != 3'b111) ? S_INDIRECT : S_EXECUTE;
      S_INDIRECT: w_next = S_EXECUTE;
      S_EXECUTE:  w_next = w_retire ? ((r_halt_pend || bus.halt_req) ? S_HALTED : S_FETCH) :
                           w_timeout ? S_HALTED : S_EXECUTE;
      S_HALTED:   w_next = w_resume ? S_FETCH : S_HALTED;
      default:    w_next = S_IDLE;
    endcase
    bus.t_sig       = w_active ? w_dec : '0;
    bus.sc_clr      = !w_active || w_retire || w_timeout;
    bus.sc_inc      = w_active && !w_retire && !w_timeout;
    bus.ld_ar       = r_state == S_FETCH && w_dec[0];
    bus.ld_ir       = r_state == S_FETCH && w_dec[1];
    bus.dec_stb     = r_state == S_DECODE;
    bus.ind_stb     = r_state == S_INDIRECT;
    bus.instr_done  = w_retire;
    bus.halted      = r_state == S_HALTED;
    bus.err_timeout = r_err_timeout;
    bus.instr_count = r_instr_count;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_halt_pend   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state       <= w_next;
      r_halt_pend   <= w_resume ? 1'b0 : (r_halt_pend || (w_active && bus.halt_req));
      r_err_timeout <= w_resume ? 1'b0 : (r_err_timeout || w_timeout);
      r_instr_count <= r_instr_count + CNT_W'(w_retire);
    end
  end
endmodule

// File: tb/tb_seq_timing_ctrl.sv
// tb_seq_timing_ctrl: directed cycle-by-cycle checks with a behavioural sequence counter in the loop
module tb_seq_timing_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0, halt_req = 1'b0, ir_ind = 1'b0;
  logic [2:0] ir_op = 3'b000;
  logic [2:0] sc = 3'd0;
  int         exec_at = 3;
  int         tests = 0, fails = 0;
  int         n;
  seq_timing_ctrl_if #(.SC_W(3), .CNT_W(16)) bus ();
  seq_timing_ctrl_if #(.SC_W(3), .CNT_W(3))  bus2 ();
  seq_timing_ctrl #(.SC_W(3), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  seq_timing_ctrl #(.SC_W(3), .CNT_W(3))  dut2 (.clk(clk), .reset(reset), .bus(bus2));
  assign bus.sc_number  = sc;
  assign bus.run        = run;
  assign bus.halt_req   = halt_req;
  assign bus.ir_op      = ir_op;
  assign bus.ir_ind     = ir_ind;
  assign bus.exec_done  = int'(sc) == exec_at;
  assign bus2.sc_number = sc;
  assign bus2.run       = run;
  assign bus2.halt_req  = halt_req;
  assign bus2.ir_op     = ir_op;
  assign bus2.ir_ind    = ir_ind;
  assign bus2.exec_done = int'(sc) == exec_at;
  always #5 clk = ~clk;
  always @(posedge clk) sc <= bus.sc_clr ? 3'd0 : bus.sc_inc ? sc + 3'd1 : sc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  // strobes = {ld_ar, ld_ir, dec_stb, ind_stb, instr_done, sc_inc}
  task automatic cyc(input string tag, input logic [7:0] t, input logic [5:0] s);
    chk({tag, "_t"}, 32'(bus.t_sig), 32'(t));
    chk({tag, "_s"}, 32'({bus.ld_ar, bus.ld_ir, bus.dec_stb, bus.ind_stb, bus.instr_done, bus.sc_inc}), 32'(s));
  endtask
  initial begin
    repeat (2) step;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      chk("idle_clr", 32'(bus.sc_clr), 1);
      chk("idle_t", 32'(bus.t_sig), 0);
      chk("idle_cnt", 32'(bus.instr_count), 0);
      chk("idle_halt", 32'(bus.halted), 0);
    end
    run = 1'b1;
    step; cyc("a0", 8'h01, 6'b100001);
    step; cyc("a1", 8'h02, 6'b010001);
    step; cyc("a2", 8'h04, 6'b001001);
    step; cyc("a3", 8'h08, 6'b000010); chk("a3_clr", 32'(bus.sc_clr), 1);
    step; cyc("a4", 8'h01, 6'b100001); chk("a_cnt", 32'(bus.instr_count), 1);
    ir_ind = 1'b1; exec_at = 4;
    step; cyc("b1", 8'h02, 6'b010001);
    step; cyc("b2", 8'h04, 6'b001001);
    step; cyc("b3", 8'h08, 6'b000101);
    step; cyc("b4", 8'h10, 6'b000010);
    step; cyc("b5", 8'h01, 6'b100001); chk("b_cnt", 32'(bus.instr_count), 2);
    ir_op = 3'b111; exec_at = 3;
    step; cyc("c1", 8'h02, 6'b010001);
    step; cyc("c2", 8'h04, 6'b001001);
    step; cyc("c3", 8'h08, 6'b000010);
    step; cyc("c4", 8'h01, 6'b100001); chk("c_cnt", 32'(bus.instr_count), 3);
    ir_op = 3'b000; ir_ind = 1'b0; exec_at = 8;
    step; step;
    step; cyc("d3", 8'h08, 6'b000001);
    step; cyc("d4", 8'h10, 6'b000001);
    step; step;
    step; cyc("d7", 8'h80, 6'b000000); chk("d7_clr", 32'(bus.sc_clr), 1);
    run = 1'b0;
    step;
    chk("to_err", 32'(bus.err_timeout), 1);
    chk("to_halt", 32'(bus.halted), 1);
    chk("to_t", 32'(bus.t_sig), 0);
    chk("to_cnt", 32'(bus.instr_count), 3);
    step; chk("to_hold", 32'(bus.halted), 1);
    run = 1'b1; exec_at = 3;
    step; cyc("e0", 8'h01, 6'b100001);
    chk("e_err", 32'(bus.err_timeout), 0);
    chk("e_halt", 32'(bus.halted), 0);
    step; cyc("f1", 8'h02, 6'b010001); halt_req = 1'b1;
    step; halt_req = 1'b0;
    step; cyc("f3", 8'h08, 6'b000010);
    step; chk("f_halt", 32'(bus.halted), 1); chk("f_cnt", 32'(bus.instr_count), 4);
    halt_req = 1'b1;
    step; chk("f_stay1", 32'(bus.halted), 1);
    step; chk("f_stay2", 32'(bus.halted), 1);
    halt_req = 1'b0;
    step; cyc("g0", 8'h01, 6'b100001); chk("g_halt", 32'(bus.halted), 0);
    step; step;
    step; cyc("g3", 8'h08, 6'b000010);
    step; cyc("g4", 8'h01, 6'b100001); chk("g_cnt", 32'(bus.instr_count), 5);
    step; step;
    step; cyc("h3", 8'h08, 6'b000010);
    reset = 1'b0;
    #1;
    cyc("rst", 8'h00, 6'b000000);
    chk("rst_clr", 32'(bus.sc_clr), 1);
    chk("rst_cnt", 32'(bus.instr_count), 0);
    chk("rst_halt", 32'(bus.halted), 0);
    step; reset = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 9; i++) begin
      step;
      if (bus.instr_done) n++;
    end
    step;
    chk("wrap_n", 32'(n), 9);
    chk("wrap_cnt16", 32'(bus.instr_count), 9);
    chk("wrap_cnt3", 32'(bus2.instr_count), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
